// File: rtl/idma_sched_pkg.sv
// rtl/idma_sched_pkg.sv - shared limits, index-width helper and parameter checks for idma_chan_scheduler

`define IDMA_SCHED_CHECK(cond) \
  assert property (@(posedge clk_i) (cond));

package idma_sched_pkg;

  localparam int unsigned MaxChan = 16;

  function automatic int unsigned chan_idx_width(input int unsigned num_chan);
    return (num_chan > 1) ? $clog2(num_chan) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - registered-output stream FIFO with fill-level output

module stream_fifo #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 8,
  parameter type         T            = logic,
  localparam int unsigned AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW        = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [CntW-1:0] usage_o,
  input  T                data_i,
  input  logic            valid_i,
  output logic            ready_o,
  output T                data_o,
  output logic            valid_o,
  input  logic            ready_i
);

  T                 mem_q [DEPTH];
  logic [AddrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  // Full blocks the push even when a pop happens in the same cycle.
  assign ready_o = (cnt_q != CntW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign usage_o = cnt_q;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = next_ptr(wr_q);
    if (pop)  rd_d = next_ptr(rd_q);
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end

  assert property (@(posedge clk_i) (FALL_THROUGH == 1'b0));

endmodule

// File: rtl/idma_chan_scheduler.sv
// rtl/idma_chan_scheduler.sv - round-robin job scheduler in front of one in-order iDMA backend,
// routing each backend response back to the channel that issued the job

module idma_chan_scheduler
  import idma_sched_pkg::*;
#(
  parameter int unsigned NumChan        = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         idma_req_t     = logic,
  parameter type         idma_rsp_t     = logic,
  localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  idma_req_t [NumChan-1:0] req_i,
  input  logic      [NumChan-1:0] req_valid_i,
  output logic      [NumChan-1:0] req_ready_o,
  output idma_rsp_t               rsp_o,
  output logic      [NumChan-1:0] rsp_valid_o,
  input  logic      [NumChan-1:0] rsp_ready_i,
  output idma_req_t               be_req_o,
  output logic                    be_req_valid_o,
  input  logic                    be_req_ready_i,
  input  idma_rsp_t               be_rsp_i,
  input  logic                    be_rsp_valid_i,
  output logic                    be_rsp_ready_o,
  output logic      [NumChan-1:0] chan_busy_o,
  output logic      [OutW-1:0]    outstanding_o
);

  localparam int unsigned IdxW = chan_idx_width(NumChan);
  typedef logic [IdxW-1:0] chan_idx_t;
  localparam logic [NumChan-1:0] OneHot = {{(NumChan - 1){1'b0}}, 1'b1};

  `IDMA_SCHED_CHECK(NumChan >= 2 && NumChan <= MaxChan)
  `IDMA_SCHED_CHECK(MaxOutstanding >= 2 && (MaxOutstanding & (MaxOutstanding - 1)) == 0)

  chan_idx_t        rr_q, rr_d, gnt_q, gnt_d, arb_idx, gnt, head;
  logic             lock_q, lock_d, arb_found, have_req, full, be_hs, rsp_hs;
  logic             fifo_ready, fifo_valid;
  logic [OutW-1:0]  cnt_q [NumChan];
  logic [OutW-1:0]  cnt_d [NumChan];
  logic [NumChan-1:0] inc, dec;

  function automatic chan_idx_t wrap_idx(input int unsigned v);
    return chan_idx_t'(v % NumChan);
  endfunction

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NumChan; k++) begin
      if (!arb_found && req_valid_i[wrap_idx(32'(rr_q) + k)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(32'(rr_q) + k);
      end
    end
  end

  // A stalled grant is frozen so a later, higher-priority requester cannot steal it.
  assign gnt            = lock_q ? gnt_q : arb_idx;
  assign have_req       = lock_q ? req_valid_i[gnt_q] : arb_found;
  assign full           = ~fifo_ready;
  assign be_req_o       = req_i[gnt];
  assign be_req_valid_o = have_req & ~full;
  assign be_hs          = be_req_valid_o & be_req_ready_i;
  assign req_ready_o    = be_hs ? (OneHot << gnt) : '0;

  assign rsp_o          = be_rsp_i;
  assign rsp_valid_o    = (be_rsp_valid_i & fifo_valid) ? (OneHot << head) : '0;
  assign be_rsp_ready_o = fifo_valid & rsp_ready_i[head];
  assign rsp_hs         = be_rsp_valid_i & be_rsp_ready_o;

  assign lock_d = be_req_valid_o & ~be_req_ready_i;
  assign gnt_d  = gnt;
  assign rr_d   = !be_hs ? rr_q :
                  (gnt == chan_idx_t'(NumChan - 1)) ? '0 : gnt + chan_idx_t'(1);

  always_comb begin
    for (int unsigned c = 0; c < NumChan; c++) begin
      inc[c]         = be_hs && (gnt == chan_idx_t'(c));
      dec[c]         = rsp_hs && (head == chan_idx_t'(c));
      chan_busy_o[c] = (cnt_q[c] != '0);
      cnt_d[c]       = cnt_q[c];
      if (inc[c] && !dec[c])      cnt_d[c] = cnt_q[c] + OutW'(1);
      else if (dec[c] && !inc[c]) cnt_d[c] = cnt_q[c] - OutW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
      for (int unsigned c = 0; c < NumChan; c++) cnt_q[c] <= '0;
    end else begin
      rr_q   <= rr_d;
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
      for (int unsigned c = 0; c < NumChan; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  // The backend answers in order, so the FIFO head always names the owner of the next response.
  stream_fifo #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (MaxOutstanding),
    .T            (chan_idx_t)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .usage_o (outstanding_o),
    .data_i  (gnt),
    .valid_i (be_hs),
    .ready_o (fifo_ready),
    .data_o  (head),
    .valid_o (fifo_valid),
    .ready_i (rsp_hs)
  );

  for (genvar c = 0; c < NumChan; c++) begin : g_cnt_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec[c] && !inc[c] && cnt_q[c] == '0));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(inc[c] && !dec[c] && cnt_q[c] == OutW'(MaxOutstanding)));
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> be_req_o == $past(be_req_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) be_rsp_valid_i |-> fifo_valid);

endmodule

// File: tb/tb_idma_chan_scheduler.sv
// tb/tb_idma_chan_scheduler.sv - randomized scoreboard bench for idma_chan_scheduler

module tb_idma_chan_scheduler;

  localparam int NC  = 4;
  localparam int MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0][15:0] req;
  logic [NC-1:0]     req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [15:0]       rsp, be_req, be_rsp;
  logic              be_req_valid, be_req_ready, be_rsp_valid, be_rsp_ready;
  logic [3:0]        outst;

  idma_chan_scheduler #(
    .NumChan        (NC),
    .MaxOutstanding (MAX),
    .idma_req_t     (logic [15:0]),
    .idma_rsp_t     (logic [15:0])
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .rsp_o          (rsp),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .be_req_o       (be_req),
    .be_req_valid_o (be_req_valid),
    .be_req_ready_i (be_req_ready),
    .be_rsp_i       (be_rsp),
    .be_rsp_valid_i (be_rsp_valid),
    .be_rsp_ready_o (be_rsp_ready),
    .chan_busy_o    (busy),
    .outstanding_o  (outst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          chan;
    logic [15:0] data;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        exp_q[$];
  int          route_q[$];
  logic [15:0] be_q[$];
  int          hs_log[$];
  int          m_ptr, m_gnt, m_fill;
  int          m_cnt[NC];
  bit          m_lock;
  int          last_req_hs;
  bit          last_rsp_hs;
  int          seq = 0;
  int          p_valid, p_bready, p_brsp, p_rready;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit pct(input int p);
    return int'($urandom % 100) < p;
  endfunction

  function automatic logic [15:0] rsp_of(input logic [15:0] job);
    return job ^ 16'h5A5A;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    route_q.delete();
    be_q.delete();
    m_ptr = 0; m_gnt = 0; m_fill = 0; m_lock = 1'b0;
    for (int c = 0; c < NC; c++) m_cnt[c] = 0;
    last_req_hs = -1;
    last_rsp_hs = 1'b0;
  endtask

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      if (last_req_hs == c) req_valid[c] = 1'b0;
      if (!req_valid[c] && pct(p_valid)) begin
        req_valid[c] = 1'b1;
        req[c]       = {2'(c), 14'(seq)};
        seq++;
      end
      rsp_ready[c] = pct(p_rready);
    end
    be_req_ready = pct(p_bready);
    if (last_rsp_hs) be_rsp_valid = 1'b0;
    if (!be_rsp_valid && be_q.size() > 0 && pct(p_brsp)) begin
      be_rsp_valid = 1'b1;
      be_rsp       = rsp_of(be_q[0]);
    end
    last_req_hs = -1;
    last_rsp_hs = 1'b0;
  endtask

  // Reference: round-robin from the pointer, the winner sticks while the backend stalls,
  // no issue at MaxOutstanding, responses return in issue order.
  task automatic evaluate();
    logic [NC-1:0] exp_busy;
    int  win, head, c;
    bit  ev, hs, ebr, rhs;
    for (int k = 0; k < NC; k++) exp_busy[k] = (m_cnt[k] != 0);
    chk_eq("outstanding", 32'(outst), 32'(m_fill));
    chk_eq("chan_busy", 32'(busy), 32'(exp_busy));
    win = -1;
    if (m_lock) win = m_gnt;
    else for (int k = 0; k < NC; k++) begin
      c = (m_ptr + k) % NC;
      if (win < 0 && req_valid[c]) win = c;
    end
    ev = (win >= 0) && (m_fill < MAX);
    hs = ev && be_req_ready;
    chk_eq("be_req_valid", 32'(be_req_valid), 32'(ev));
    chk_eq("req_ready", 32'(req_ready), hs ? 32'(1 << win) : 32'd0);
    if (ev) chk_eq("be_req_data", 32'(be_req), 32'(req[win]));
    head = (route_q.size() > 0) ? route_q[0] : -1;
    ebr  = (head >= 0) && rsp_ready[head];
    rhs  = be_rsp_valid && ebr;
    chk_eq("be_rsp_ready", 32'(be_rsp_ready), 32'(ebr));
    chk_eq("rsp_valid", 32'(rsp_valid), (be_rsp_valid && head >= 0) ? 32'(1 << head) : 32'd0);
    if (hs) begin
      route_q.push_back(win);
      exp_q.push_back('{chan: win, data: rsp_of(req[win])});
      be_q.push_back(req[win]);
      m_cnt[win]++;
      m_fill++;
      m_ptr = (win + 1) % NC;
      hs_log.push_back(win);
      last_req_hs = win;
    end
    m_lock = ev && !be_req_ready;
    if (m_lock) m_gnt = win;
    if (rhs) begin
      head = route_q.pop_front();
      m_cnt[head]--;
      m_fill--;
      void'(be_q.pop_front());
      last_rsp_hs = 1'b1;
    end
  endtask

  task automatic run(input int n, input int pv, input int pb, input int pr, input int prr);
    p_valid = pv; p_bready = pb; p_brsp = pr; p_rready = prr;
    repeat (n) begin
      drive();
      @(negedge clk);
      evaluate();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n        = 1'b0;
    req_valid    = '0;
    be_req_ready = 1'b0;
    be_rsp_valid = 1'b0;
    be_rsp       = '0;
    rsp_ready    = '0;
    clear_model();
    #1;
    chk_eq("rst_be_req_valid", 32'(be_req_valid), 32'd0);
    chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_be_rsp_ready", 32'(be_rsp_ready), 32'd0);
    chk_eq("rst_chan_busy", 32'(busy), 32'd0);
    chk_eq("rst_outstanding", 32'(outst), 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_rr_order(input string name);
    chk_eq({name, "_count"}, 32'(hs_log.size() >= 8), 32'd1);
    if (hs_log.size() >= 8)
      for (int i = 0; i < 8; i++) chk_eq(name, 32'(hs_log[i]), 32'(i % NC));
  endtask

  initial begin : scoreboard_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int c = 0; c < NC; c++) begin
          if (rsp_valid[c] && rsp_ready[c]) begin
            if (exp_q.size() == 0) chk_eq("rsp_unexpected_chan", 32'(c), 32'hFFFF_FFFF);
            else begin
              e = exp_q.pop_front();
              chk_eq("rsp_chan", 32'(c), 32'(e.chan));
              chk_eq("rsp_data", 32'(rsp), 32'(e.data));
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    req   = '0;
    rst_n = 1'b1;
    #1;
    do_reset(3);

    hs_log.delete();
    run(12, 100, 100, 100, 100);
    check_rr_order("rr_order");

    run(30, 60, 100, 0, 100);
    chk_eq("full_level", 32'(outst), 32'(MAX));
    run(20, 60, 100, 40, 100);

    run(400, 50, 70, 50, 70);
    run(200, 70, 80, 80, 30);

    run(10, 80, 100, 0, 100);
    run(3, 100, 0, 0, 100);
    do_reset(2);
    hs_log.delete();
    run(12, 100, 100, 100, 100);
    check_rr_order("rr_after_reset");

    run(400, 60, 50, 60, 60);

    p_valid = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_fill == 0 && exp_q.size() == 0 && req_valid == '0) break;
      run(1, 0, 100, 100, 100);
    end
    chk_eq("drain_outstanding", 32'(outst), 32'd0);
    chk_eq("drain_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
